// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: a cycle counter with a fractional accumulator
// produces oversample ticks, and an oversample counter produces bit ticks.
module baud_gen_frac #(
  parameter int INT_W     = 16,
  parameter int FRAC_W    = 4,
  parameter int OSR       = 16,
  parameter int RESET_DIV = 27
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              cfg_pend,
  output logic              cfg_err
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic [INT_W:0]    r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_ext;
  logic [OS_W-1:0]   r_os_cnt;
  logic [INT_W-1:0]  r_act_int;
  logic [FRAC_W-1:0] r_act_frac;
  logic [INT_W-1:0]  r_pend_int;
  logic [FRAC_W-1:0] r_pend_frac;
  logic              r_cfg_pend;
  logic              r_cfg_err;

  logic [INT_W:0]    w_period;
  logic [FRAC_W:0]   w_frac_sum;
  logic              w_os_tick;
  logic              w_os_last;
  logic              w_accept;
  logic              w_reject;
  logic              w_apply;

  // Period is one cycle longer whenever the previous accumulation carried out.
  assign w_period   = {1'b0, r_act_int} + (INT_W+1)'(r_ext);
  assign w_frac_sum = {1'b0, r_acc} + {1'b0, r_act_frac};
  assign w_os_tick  = resetn & en & ~resync & (r_cnt == (w_period - (INT_W+1)'(1)));
  assign w_os_last  = (r_os_cnt == OS_W'(OSR - 1));

  assign w_accept = div_load & (div_int >= INT_W'(2));
  assign w_reject = div_load & ~w_accept;
  // Pending divisors take effect only where the phase cannot be corrupted.
  assign w_apply  = r_cfg_pend & (w_os_tick | ~en | resync);

  assign os_tick  = w_os_tick;
  assign bit_tick = w_os_tick & w_os_last;
  assign cfg_pend = r_cfg_pend;
  assign cfg_err  = r_cfg_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ext    <= 1'b0;
      r_os_cnt <= '0;
    end else if (resync) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ext    <= 1'b0;
      r_os_cnt <= '0;
    end else if (en) begin
      if (w_os_tick) begin
        r_cnt    <= '0;
        r_acc    <= w_frac_sum[FRAC_W-1:0];
        r_ext    <= w_frac_sum[FRAC_W];
        r_os_cnt <= w_os_last ? '0 : r_os_cnt + OS_W'(1);
      end else begin
        r_cnt <= r_cnt + (INT_W+1)'(1);
      end
    end
  end

  // Capture after apply so a same-cycle load leaves the new request pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_act_int   <= INT_W'(RESET_DIV);
      r_act_frac  <= '0;
      r_pend_int  <= '0;
      r_pend_frac <= '0;
      r_cfg_pend  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_reject;
      if (w_apply) begin
        r_act_int  <= r_pend_int;
        r_act_frac <= r_pend_frac;
        r_cfg_pend <= 1'b0;
      end
      if (w_accept) begin
        r_pend_int  <= div_int;
        r_pend_frac <= div_frac;
        r_cfg_pend  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed tick-interval scenarios plus randomized
// traffic checked cycle by cycle against a behavioural model.
module tb_baud_gen_frac;
  localparam int INT_W     = 16;
  localparam int FRAC_W    = 4;
  localparam int OSR       = 16;
  localparam int RESET_DIV = 27;

  logic              clk;
  logic              resetn;
  logic              en;
  logic [INT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              resync;
  logic              os_tick;
  logic              bit_tick;
  logic              cfg_pend;
  logic              cfg_err;

  baud_gen_frac #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .OSR(OSR), .RESET_DIV(RESET_DIV)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .resync(resync), .os_tick(os_tick), .bit_tick(bit_tick),
    .cfg_pend(cfg_pend), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  longint cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint os_q[$];
  longint bit_q[$];

  // Model: elapsed enabled cycles in the current period, fractional remainder.
  int m_elapsed, m_acc, m_ext, m_os;
  int m_act_int, m_act_frac, m_pend_int, m_pend_frac;
  bit m_pend, m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_acc = 0; m_ext = 0; m_os = 0;
    m_act_int = RESET_DIV; m_act_frac = 0;
    m_pend_int = 0; m_pend_frac = 0; m_pend = 0; m_err = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit e_os, e_bit, apply;
    int s;
    if (!resetn) begin
      model_reset();
      check("os_tick_rst", os_tick, 0);
      check("bit_tick_rst", bit_tick, 0);
      check("cfg_pend_rst", cfg_pend, 0);
      check("cfg_err_rst", cfg_err, 0);
    end else begin
      e_os  = en && !resync && (m_elapsed + 1 == m_act_int + m_ext);
      e_bit = e_os && (m_os == OSR - 1);
      check("os_tick", os_tick, e_os);
      check("bit_tick", bit_tick, e_bit);
      check("cfg_pend", cfg_pend, m_pend);
      check("cfg_err", cfg_err, m_err);
      if (os_tick) os_q.push_back(cyc);
      if (bit_tick) bit_q.push_back(cyc);
      apply = m_pend && (e_os || !en || resync);
      if (resync) begin
        m_elapsed = 0; m_acc = 0; m_ext = 0; m_os = 0;
      end else if (en) begin
        if (e_os) begin
          s = m_acc + m_act_frac;
          m_elapsed = 0;
          m_acc = s % (2 ** FRAC_W);
          m_ext = s / (2 ** FRAC_W);
          m_os = (m_os + 1) % OSR;
        end else begin
          m_elapsed++;
        end
      end
      if (apply) begin
        m_act_int = m_pend_int; m_act_frac = m_pend_frac; m_pend = 0;
      end
      if (div_load && div_int >= 2) begin
        m_pend_int = div_int; m_pend_frac = div_frac; m_pend = 1;
      end
      m_err = div_load && (div_int < 2);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart_record();
    os_q.delete();
    bit_q.delete();
    os_q.push_back(cyc - 1);
    bit_q.push_back(cyc - 1);
  endtask

  // Load with en low (applies immediately), then resync for a fresh phase.
  task automatic configure(input int di, input int df);
    en = 1'b0;
    div_int = INT_W'(di);
    div_frac = FRAC_W'(df);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    en = 1'b1;
    restart_record();
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int b;
    b = budget;
    while (os_q.size() < n + 1 && b > 0) begin
      step();
      b--;
    end
    check("os_tick_count", os_q.size() >= n + 1, 1);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int b;
    b = budget;
    while (bit_q.size() < n + 1 && b > 0) begin
      step();
      b--;
    end
    check("bit_tick_count", bit_q.size() >= n + 1, 1);
  endtask

  function automatic longint ival(input int k);
    if (os_q.size() > k) return os_q[k] - os_q[k-1];
    return -1;
  endfunction

  initial begin
    int exp_frac[5];
    exp_frac = '{4, 4, 5, 4, 5};
    resetn = 1'b0; en = 1'b0; div_int = '0; div_frac = '0; div_load = 1'b0; resync = 1'b0;
    step(2);
    check("cfg_pend_init", cfg_pend, 0);
    resetn = 1'b1;
    step();

    // Integer divisor 4: os every 4 cycles, bit every 64.
    configure(4, 0);
    wait_bits(2, 300);
    for (int k = 1; k <= 5; k++) check("int4_period", ival(k), 4);
    if (bit_q.size() >= 3) begin
      check("int4_bit_period1", bit_q[1] - bit_q[0], 64);
      check("int4_bit_period2", bit_q[2] - bit_q[1], 64);
    end

    // 4.5 cycles per tick.
    configure(4, 8);
    wait_ticks(33, 400);
    for (int k = 1; k <= 5; k++) check("frac_period", ival(k), exp_frac[k-1]);
    if (os_q.size() >= 34) check("frac_sum32", os_q[33] - os_q[1], 144);

    // Rejected load, then the smallest accepted divisor.
    configure(4, 0);
    wait_ticks(2, 50);
    div_int = 1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("reject_err_pulse", cfg_err, 1);
    check("reject_no_pend", cfg_pend, 0);
    step();
    check("reject_err_end", cfg_err, 0);
    wait_ticks(6, 60);
    for (int k = 3; k <= 6; k++) check("reject_period", ival(k), 4);
    div_int = 2; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("accept2_pend", cfg_pend, 1);
    check("accept2_no_err", cfg_err, 0);
    wait_ticks(9, 60);
    check("accept2_period", ival(9), 2);

    // Mid-period reload: current period keeps old divisor.
    configure(10, 0);
    wait_ticks(1, 50);
    step(3);
    div_int = 6; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("reload_pend", cfg_pend, 1);
    wait_ticks(3, 80);
    check("reload_old_period", ival(2), 10);
    check("reload_new_period", ival(3), 6);
    check("reload_pend_clear", cfg_pend, 0);

    // Resync at cnt=5.
    configure(8, 0);
    step(5);
    resync = 1'b1;
    #2;
    check("resync_no_tick", os_tick, 0);
    step();
    resync = 1'b0;
    restart_record();
    wait_bits(1, 200);
    check("resync_first_os", ival(1), 8);
    if (bit_q.size() >= 2) check("resync_first_bit", bit_q[1] - bit_q[0], 128);

    // Enable low for 7 cycles mid-period.
    configure(8, 0);
    step(3);
    en = 1'b0;
    step(7);
    en = 1'b1;
    wait_ticks(1, 50);
    check("en_gap_period", ival(1), 15);

    // Reset pulse mid-period.
    step(4);
    resetn = 1'b0;
    #1;
    check("rst_os_low", os_tick, 0);
    check("rst_bit_low", bit_tick, 0);
    check("rst_err_low", cfg_err, 0);
    step();
    resetn = 1'b1;
    restart_record();
    wait_ticks(1, 60);
    check("rst_div_period", ival(1), RESET_DIV);

    // Randomized traffic; en stays high while a load is pending.
    for (int i = 0; i < 4000; i++) begin
      resetn   = ($urandom_range(0, 1999) != 0);
      en       = ($urandom_range(0, 9) != 0) || m_pend;
      resync   = ($urandom_range(0, 49) == 0);
      div_load = ($urandom_range(0, 24) == 0);
      div_int  = INT_W'($urandom_range(0, 9));
      div_frac = FRAC_W'($urandom);
      step();
    end
    resetn = 1'b1; div_load = 1'b0; resync = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter INT_W, default 16: width of the integer divisor.
REQ-002 SHALL have parameter FRAC_W, default 4: width of the fractional divisor, with LSB weight 2^-FRAC_W.
REQ-003 SHALL have parameter OSR, default 16: oversample ticks per bit; legal range 2..256.
REQ-004 SHALL have parameter RESET_DIV, default 27: integer divisor loaded at reset; must be >= 2.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1 bit: count enable.
REQ-008 SHALL have port div_int, input, INT_W bits: requested integer divisor.
REQ-009 SHALL have port div_frac, input, FRAC_W bits: requested fractional divisor.
REQ-010 SHALL have port div_load, input, 1 bit: single-cycle request to load div_int/div_frac.
REQ-011 SHALL have port resync, input, 1 bit: restarts the phase of all counters (receiver start-bit alignment).
REQ-012 SHALL have port os_tick, output, 1 bit: oversample tick, one cycle wide.
REQ-013 SHALL have port bit_tick, output, 1 bit: bit-rate tick, one cycle wide.
REQ-014 SHALL have port cfg_pend, output, 1 bit: an accepted load is waiting to be applied.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging a rejected load.

Function
REQ-016 SHALL hold these state registers: cycle counter cnt (INT_W+1 bits), fractional accumulator acc (FRAC_W bits), extend flag ext, oversample counter os_cnt (clog2(OSR) bits), active divisor act_int/act_frac, pending divisor pend_int/pend_frac, and the cfg_pend flag.
REQ-017 SHALL compute the current period as act_int + ext cycles, with width INT_W+1 so no overflow occurs.
REQ-018 SHALL assert os_tick combinationally when en=1, resync=0 and cnt == period-1.
REQ-019 SHALL, in an os_tick cycle, set cnt to 0, set acc to the low FRAC_W bits of acc+act_frac, and set ext to the carry out of that sum.
REQ-020 SHALL otherwise, with en=1, increment cnt by 1.
REQ-021 SHALL give a long-run average period of act_int + act_frac/2^FRAC_W cycles.
REQ-022 SHALL assert bit_tick only when os_tick=1 and os_cnt == OSR-1.
REQ-023 SHALL increment os_cnt on every os_tick, wrapping from OSR-1 to 0.
REQ-024 SHALL, when en=0, hold cnt, acc, ext and os_cnt, and keep os_tick and bit_tick at 0.
REQ-025 SHALL, when resync=1, synchronously clear cnt, acc, ext and os_cnt, with no tick that cycle.
REQ-026 SHALL give resync priority over os_tick and over en.
REQ-027 SHALL treat div_load with div_int < 2 as a rejected load: cfg_err pulses for exactly 1 cycle next cycle, and pend and active registers are unchanged.
REQ-028 SHALL treat div_load with div_int >= 2 as an accepted load: capture into pend_*, set cfg_pend=1 next cycle, and let a later load before application overwrite pend_*.
REQ-029 SHALL apply a pending divisor (act_* := pend_*, cfg_pend := 0) in an os_tick cycle; the tick completes under the old divisor and the next period uses the new one.
REQ-030 SHALL also apply a pending divisor in any cycle with en=0, or with resync=1.
REQ-031 SHALL leave acc and ext unchanged when a divisor is applied.
REQ-032 SHALL, when div_load and an apply occur in the same cycle, apply the old pend_* and capture the new request, leaving cfg_pend=1.

Reset
REQ-033 SHALL, on resetn=0 asynchronously, set cnt=0, acc=0, ext=0, os_cnt=0, act_int=RESET_DIV, act_frac=0, pend_*=0, cfg_pend=0.
REQ-034 SHALL force os_tick, bit_tick and cfg_err to 0 while resetn=0.
REQ-035 SHALL, after resetn deasserts mid-operation, restart counting from cnt=0, so the first os_tick arrives RESET_DIV cycles after the first enabled edge.

Verification
REQ-036 SHALL verify: load int=4, frac=0, en=1 -> os_tick every 4 cycles, bit_tick (OSR=16) every 64 cycles.
REQ-037 SHALL verify: int=4, frac=8 (FRAC_W=4) from a fresh state -> tick-to-tick periods 4,4,5,4,5,... with an average of 4.5 over 32 ticks.
REQ-038 SHALL verify: div_load with int=1 -> cfg_err high for exactly 1 cycle, cfg_pend stays 0, period unchanged.
REQ-039 SHALL verify: int=10 running, load int=6 mid-period -> current period stays 10, next period 6, cfg_pend falls at the boundary tick.
REQ-040 SHALL verify: resync asserted at cnt=5 -> no tick that cycle, next os_tick act_int cycles later, bit_tick after OSR os_ticks.
REQ-041 SHALL verify: en low for 7 cycles mid-period -> tick delayed by exactly 7 cycles, no ticks while low; resetn pulse mid-period -> outputs 0 immediately, divisor returns to RESET_DIV.
